// File: rtl/team_11_wb_master.sv
// Single-outstanding Wishbone classic master for the team_11 core.
// Each core request becomes one bus cycle and one response, aborted with an error if the slave never ACKs.
module team_11_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 32'd1 : 32'd0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               stb_q, stb_d;
  logic               cyc_q, cyc_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               timeout_hit;

  // Word-aligned bus: the byte offset of the request address is dropped.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^req_adr[1:0];

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    stb_d       = stb_q;
    cyc_d       = cyc_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_dat_d   = '0;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          adr_d   = {req_adr[31:2], 2'b00};
          dat_d   = req_we ? req_dat : 32'd0;
          sel_d   = req_sel;
          we_d    = req_we;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (ACK_I || timeout_hit) begin
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          we_d        = 1'b0;
          stb_d       = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
          if (ACK_I) begin
            rsp_dat_d = we_q ? 32'd0 : DAT_I;
          end else begin
            rsp_err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !wb_rst_i;
  assign busy      = (state_q != S_IDLE) && !wb_rst_i;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_dat   = rsp_dat_q;
  assign err_count = err_cnt_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign SEL_O     = sel_q;
  assign WE_O      = we_q;
  assign STB_O     = stb_q;
  assign CYC_O     = cyc_q;

endmodule
